// File: rtl/sys_reset_sequencer.sv
// Board reset sequencer. Waits for a stable PLL lock, then releases peripheral reset and later core reset.
// Latency: lock to periph release is 2+LOCK_STABLE_CYCLES edges. All outputs are registered.
// No backpressure. Optional software reset request is enabled by `SYS_RESET_SWREQ_EN.
module sys_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int PERIPH_TO_CORE_CYCLES = 16,
    parameter int SWRESET_HOLD_CYCLES   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
`ifdef SYS_RESET_SWREQ_EN
    input  logic       sw_reset_req,
`endif
    output logic       periph_reset,
    output logic       core_reset,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int MAXP_A = (LOCK_STABLE_CYCLES > PERIPH_TO_CORE_CYCLES) ?
                            LOCK_STABLE_CYCLES : PERIPH_TO_CORE_CYCLES;
    localparam int MAXP   = (MAXP_A > SWRESET_HOLD_CYCLES) ? MAXP_A : SWRESET_HOLD_CYCLES;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] LS_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] P2C_LAST = CW'(PERIPH_TO_CORE_CYCLES - 1);
`ifdef SYS_RESET_SWREQ_EN
    localparam logic [CW-1:0] SW_LAST  = CW'(SWRESET_HOLD_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        PERIPH_RUN = 3'd2,
        RUN        = 3'd3
`ifdef SYS_RESET_SWREQ_EN
        , SW_HOLD  = 3'd4
`endif
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    r_loss_cnt;
    logic [7:0]    w_loss_nxt;
    logic          r_sync1;
    logic          r_lock_s;
    logic          r_periph_reset;
    logic          r_core_reset;
    logic          r_ready;
    logic          w_lost;
`ifdef SYS_RESET_SWREQ_EN
    logic          w_sw_go;
`endif

    // Losing lock only counts once the peripherals have been let out of reset.
    assign w_lost = !r_lock_s && ((r_state == PERIPH_RUN) || (r_state == RUN)
`ifdef SYS_RESET_SWREQ_EN
                                  || (r_state == SW_HOLD)
`endif
                                 );

`ifdef SYS_RESET_SWREQ_EN
    assign w_sw_go = sw_reset_req && ((r_state == PERIPH_RUN) || (r_state == RUN));
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_nxt  = r_loss_cnt;
        if (w_lost) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            if (r_loss_cnt != 8'hFF) begin
                w_loss_nxt = r_loss_cnt + 8'd1;
            end
`ifdef SYS_RESET_SWREQ_EN
        end else if (w_sw_go) begin
            w_state_nxt = SW_HOLD;
            w_cnt_nxt   = '0;
`endif
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = STABILIZE;
                        w_cnt_nxt   = '0;
                    end
                end
                STABILIZE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LS_LAST) begin
                        w_state_nxt = PERIPH_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PERIPH_RUN: begin
                    if (r_cnt == P2C_LAST) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
`ifdef SYS_RESET_SWREQ_EN
                // Lock is known good here, so the hold returns straight to PERIPH_RUN.
                SW_HOLD: begin
                    if (r_cnt == SW_LAST) begin
                        w_state_nxt = PERIPH_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= WAIT_LOCK;
            r_cnt          <= '0;
            r_loss_cnt     <= 8'd0;
            r_sync1        <= 1'b0;
            r_lock_s       <= 1'b0;
            r_periph_reset <= 1'b1;
            r_core_reset   <= 1'b1;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_loss_cnt     <= w_loss_nxt;
            r_sync1        <= pll_locked;
            r_lock_s       <= r_sync1;
            r_periph_reset <= !((w_state_nxt == PERIPH_RUN) || (w_state_nxt == RUN));
            r_core_reset   <= (w_state_nxt != RUN);
            r_ready        <= (w_state_nxt == RUN);
        end
    end

    assign periph_reset    = r_periph_reset;
    assign core_reset      = r_core_reset;
    assign ready           = r_ready;
    assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Directed bench for sys_reset_sequencer with LOCK_STABLE=8, PERIPH_TO_CORE=4, SWRESET_HOLD=6.
module tb_sys_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_locked;
`ifdef SYS_RESET_SWREQ_EN
    logic       sw_reset_req;
`endif
    logic       periph_reset;
    logic       core_reset;
    logic       ready;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    sys_reset_sequencer #(
        .LOCK_STABLE_CYCLES   (8),
        .PERIPH_TO_CORE_CYCLES(4),
        .SWRESET_HOLD_CYCLES  (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
`ifdef SYS_RESET_SWREQ_EN
        .sw_reset_req   (sw_reset_req),
`endif
        .periph_reset   (periph_reset),
        .core_reset     (core_reset),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic c, input logic r);
        chk({tag, ".periph"}, {31'd0, periph_reset}, {31'd0, p});
        chk({tag, ".core"},   {31'd0, core_reset},   {31'd0, c});
        chk({tag, ".ready"},  {31'd0, ready},        {31'd0, r});
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b0;
`endif
        tick(3);
        chk_out("rst", 1'b1, 1'b1, 1'b0);
        chk("rst.count", {24'd0, lock_loss_count}, 32'd0);

        // Clean bring-up: the next edge is E0.
        reset = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(10);
        chk_out("up.E9", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("up.E10", 1'b0, 1'b1, 1'b0);
        tick(3);
        chk_out("up.E13", 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_out("up.E14", 1'b0, 1'b0, 1'b1);
        chk("up.count", {24'd0, lock_loss_count}, 32'd0);

        // Lock loss in RUN, then full re-sequence.
        pll_locked = 1'b0;
        tick(2);
        chk_out("loss.L1", 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("loss.L2", 1'b1, 1'b1, 1'b0);
        chk("loss.count1", {24'd0, lock_loss_count}, 32'd1);
        pll_locked = 1'b1;
        tick(10);
        chk_out("reup.E9", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("reup.E10", 1'b0, 1'b1, 1'b0);
        tick(4);
        chk_out("reup.E14", 1'b0, 1'b0, 1'b1);

        // Lock drop coinciding with a software request: the loss wins.
        pll_locked = 1'b0;
        tick(2);
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b1;
`endif
        tick(1);
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b0;
`endif
        chk_out("simul.L2", 1'b1, 1'b1, 1'b0);
        chk("simul.count2", {24'd0, lock_loss_count}, 32'd2);
        tick(8);
        chk_out("simul.hold", 1'b1, 1'b1, 1'b0);

        // Unstable lock: high 5, low 1, high; STABILIZE restarts at E8.
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(10);
        chk_out("glitch.E15", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("glitch.E16", 1'b0, 1'b1, 1'b0);
        tick(4);
        chk_out("glitch.E20", 1'b0, 1'b0, 1'b1);
        chk("glitch.count", {24'd0, lock_loss_count}, 32'd2);

        // Software reset pulse in RUN (no effect without the feature).
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b1;
`endif
        tick(1);
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b0;
        chk_out("sw.S0", 1'b1, 1'b1, 1'b0);
        tick(5);
        chk_out("sw.S5", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("sw.S6", 1'b0, 1'b1, 1'b0);
        tick(3);
        chk_out("sw.S9", 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_out("sw.S10", 1'b0, 1'b0, 1'b1);
`else
        chk_out("nosw.S0", 1'b0, 1'b0, 1'b1);
        tick(6);
        chk_out("nosw.S6", 1'b0, 1'b0, 1'b1);
        tick(4);
        chk_out("nosw.S10", 1'b0, 1'b0, 1'b1);
`endif
        chk("sw.count", {24'd0, lock_loss_count}, 32'd2);

        // Software request during STABILIZE is ignored.
        pll_locked = 1'b0;
        tick(3);
        chk("stab.count3", {24'd0, lock_loss_count}, 32'd3);
        pll_locked = 1'b1;
        tick(3);
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b1;
`endif
        tick(1);
`ifdef SYS_RESET_SWREQ_EN
        sw_reset_req = 1'b0;
`endif
        tick(6);
        chk_out("stab.E9", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("stab.E10", 1'b0, 1'b1, 1'b0);

        // Board reset in PERIPH_RUN: everything clears, including the synchronizer.
        reset = 1'b1;
        tick(1);
        chk_out("rstpr", 1'b1, 1'b1, 1'b0);
        chk("rstpr.count", {24'd0, lock_loss_count}, 32'd0);
        reset = 1'b0;
        tick(10);
        chk_out("rstpr.E9", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("rstpr.E10", 1'b0, 1'b1, 1'b0);
        tick(4);
        chk_out("rstpr.E14", 1'b0, 1'b0, 1'b1);

        // Saturation: each pass drops lock and re-locks into PERIPH_RUN.
        for (int i = 0; i < 254; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(11);
        end
        chk("sat.count254", {24'd0, lock_loss_count}, 32'd254);
        chk_out("sat.pr", 1'b0, 1'b1, 1'b0);
        pll_locked = 1'b0;
        tick(3);
        chk("sat.count255", {24'd0, lock_loss_count}, 32'd255);
        pll_locked = 1'b1;
        tick(11);
        pll_locked = 1'b0;
        tick(3);
        chk("sat.hold255", {24'd0, lock_loss_count}, 32'd255);
        chk_out("sat.end", 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
